gpio_pad_array: RTL and testbench

- Synthesizable behavioural model of a vector of configurable FPGA I/O pad cells, equivalent to the subset of the iCE40 SB_IO cell the board top uses.
- Used for the PMOD/header ports, the LED and misc outputs, and the UART RX input.
- Lets the CPU I/O fabric be simulated and linted without vendor primitives.
- The tristate pad is split into explicit drive, enable and sample signals; the board wrapper builds the real inout.

---
 rtl/gpio_pad_pkg.sv | 19 +
 rtl/gpio_pad_array_if.sv | 25 ++
 rtl/gpio_pad_bit.sv | 86 ++++++++
 rtl/gpio_pad_array.sv | 39 +++
 tb/tb_gpio_pad_array.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/gpio_pad_pkg.sv
// rtl/gpio_pad_pkg.sv - shared pad mode encodings for the gpio pad array
// Purpose: PIN_TYPE field encodings (output mode in [5:2], input mode in [1:0])
//          and the common composite pin types used by the board top.
package gpio_pad_pkg;

    localparam logic [3:0] PIN_OUT_NONE      = 4'b0000;
    localparam logic [3:0] PIN_OUT_DIRECT    = 4'b0110;
    localparam logic [3:0] PIN_OUT_REG       = 4'b0101;
    localparam logic [3:0] PIN_OUT_REG_EN    = 4'b1001;
    localparam logic [3:0] PIN_OUT_REG_REGEN = 4'b1101;

    localparam logic [1:0] PIN_IN_REG        = 2'b00;
    localparam logic [1:0] PIN_IN_DIRECT     = 2'b01;

    localparam logic [5:0] PIN_TYPE_IOPORT   = 6'b1001_01;
    localparam logic [5:0] PIN_TYPE_OUTPIN   = 6'b0101_01;
    localparam logic [5:0] PIN_TYPE_INPIN    = 6'b0000_00;

endpackage

// File: rtl/gpio_pad_array_if.sv
// rtl/gpio_pad_array_if.sv - fabric/pad signal bundle for the gpio pad array
// Purpose: groups the per-bit data, direction and pad-side signals.
// master: fabric + pad environment (drives d_out, output_enable, clock_enable, pad_in)
// slave : the pad array (drives d_in, pad_out, pad_oe)
interface gpio_pad_array_if #(
    parameter int WIDTH = 8
);
    logic             clock_enable;
    logic [WIDTH-1:0] d_out;
    logic [WIDTH-1:0] output_enable;
    logic [WIDTH-1:0] d_in;
    logic [WIDTH-1:0] pad_out;
    logic [WIDTH-1:0] pad_oe;
    logic [WIDTH-1:0] pad_in;

    modport master (
        output clock_enable, d_out, output_enable, pad_in,
        input  d_in, pad_out, pad_oe
    );

    modport slave (
        input  clock_enable, d_out, output_enable, pad_in,
        output d_in, pad_out, pad_oe
    );
endinterface

// File: rtl/gpio_pad_bit.sv
// rtl/gpio_pad_bit.sv - single configurable pad cell
// Purpose: one bit of the pad array; output/input mode fixed by PIN_TYPE.
// Ports: clk, reset (async, active-high), clock_enable gates all registers,
//        d_out/output_enable from fabric, d_in to fabric,
//        pad_out/pad_oe toward the pad, pad_in from the pad.
module gpio_pad_bit
    import gpio_pad_pkg::*;
#(
    parameter logic [5:0] PIN_TYPE = PIN_TYPE_IOPORT
) (
    input  logic clk,
    input  logic reset,
    input  logic clock_enable,
    input  logic d_out,
    input  logic output_enable,
    input  logic pad_in,
    output logic d_in,
    output logic pad_out,
    output logic pad_oe
);

    localparam logic [3:0] OUT_MODE = PIN_TYPE[5:2];
    // Latch input modes (10/11) are not modelled and fall back to direct.
    localparam bit         IN_REG   = (PIN_TYPE[1:0] == PIN_IN_REG);

    logic out_q, out_d;
    logic oe_q, oe_d;
    logic in_q, in_d;
    logic pad_lvl;

    always_comb begin
        out_d = out_q;
        oe_d  = oe_q;
        in_d  = in_q;
        if (clock_enable) begin
            out_d = d_out;
            oe_d  = output_enable;
            in_d  = pad_lvl;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= 1'b0;
            oe_q  <= 1'b0;
            in_q  <= 1'b0;
        end else begin
            out_q <= out_d;
            oe_q  <= oe_d;
            in_q  <= in_d;
        end
    end

    // Unknown output codes fall through to the no-output default.
    always_comb begin
        pad_out = 1'b0;
        pad_oe  = 1'b0;
        case (OUT_MODE)
            PIN_OUT_DIRECT: begin
                pad_out = d_out;
                pad_oe  = 1'b1;
            end
            PIN_OUT_REG: begin
                pad_out = out_q;
                pad_oe  = 1'b1;
            end
            PIN_OUT_REG_EN: begin
                pad_out = out_q;
                pad_oe  = output_enable;
            end
            PIN_OUT_REG_REGEN: begin
                pad_out = out_q;
                pad_oe  = oe_q;
            end
            default: begin
                pad_out = 1'b0;
                pad_oe  = 1'b0;
            end
        endcase
    end

    // Readback sees our own drive when the pad is driven.
    assign pad_lvl = pad_oe ? pad_out : pad_in;
    assign d_in    = IN_REG ? in_q : pad_lvl;

endmodule

// File: rtl/gpio_pad_array.sv
// rtl/gpio_pad_array.sv - vector of independent configurable pad cells
// Purpose: WIDTH copies of gpio_pad_bit sharing one PIN_TYPE.
// Ports: clk, reset (async, active-high), bus (slave side of gpio_pad_array_if).
module gpio_pad_array
    import gpio_pad_pkg::*;
#(
    parameter int          WIDTH    = 8,
    parameter logic [5:0]  PIN_TYPE = PIN_TYPE_IOPORT
) (
    input  logic                   clk,
    input  logic                   reset,
    gpio_pad_array_if.slave        bus
);

    logic [WIDTH-1:0] d_in_w;
    logic [WIDTH-1:0] pad_out_w;
    logic [WIDTH-1:0] pad_oe_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_pad_bit #(
            .PIN_TYPE (PIN_TYPE)
        ) u_bit (
            .clk           (clk),
            .reset         (reset),
            .clock_enable  (bus.clock_enable),
            .d_out         (bus.d_out[i]),
            .output_enable (bus.output_enable[i]),
            .pad_in        (bus.pad_in[i]),
            .d_in          (d_in_w[i]),
            .pad_out       (pad_out_w[i]),
            .pad_oe        (pad_oe_w[i])
        );
    end

    assign bus.d_in    = d_in_w;
    assign bus.pad_out = pad_out_w;
    assign bus.pad_oe  = pad_oe_w;

endmodule

// File: tb/tb_gpio_pad_array.sv
// tb/tb_gpio_pad_array.sv - self-checking bench for gpio_pad_array
module tb_gpio_pad_array;

    logic clk;
    logic reset;

    int total;
    int bad;

    gpio_pad_array_if #(.WIDTH(8)) io_if ();
    gpio_pad_array_if #(.WIDTH(1)) out_if ();
    gpio_pad_array_if #(.WIDTH(1)) in_if ();
    gpio_pad_array_if #(.WIDTH(1)) rgn_if ();
    gpio_pad_array_if #(.WIDTH(1)) und_if ();
    gpio_pad_array_if #(.WIDTH(4)) dir_if ();

    gpio_pad_array #(.WIDTH(8), .PIN_TYPE(6'b1001_01)) u_io  (.clk(clk), .reset(reset), .bus(io_if));
    gpio_pad_array #(.WIDTH(1), .PIN_TYPE(6'b0101_01)) u_out (.clk(clk), .reset(reset), .bus(out_if));
    gpio_pad_array #(.WIDTH(1), .PIN_TYPE(6'b0000_00)) u_in  (.clk(clk), .reset(reset), .bus(in_if));
    gpio_pad_array #(.WIDTH(1), .PIN_TYPE(6'b1101_01)) u_rgn (.clk(clk), .reset(reset), .bus(rgn_if));
    gpio_pad_array #(.WIDTH(1), .PIN_TYPE(6'b0011_10)) u_und (.clk(clk), .reset(reset), .bus(und_if));
    gpio_pad_array #(.WIDTH(4), .PIN_TYPE(6'b0110_01)) u_dir (.clk(clk), .reset(reset), .bus(dir_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d_out;
        logic [7:0] oe;
        logic [7:0] pin;
        logic       ce;
        logic [7:0] exp_po;
        logic [7:0] exp_oe;
        logic [7:0] exp_din;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0] = '{8'hA5, 8'h0F, 8'h3C, 1'b1, 8'hA5, 8'h0F, 8'h35};
        vecs[1] = '{8'hFF, 8'h0F, 8'h3C, 1'b0, 8'hA5, 8'h0F, 8'h35};
        vecs[2] = '{8'hFF, 8'h0F, 8'h3C, 1'b0, 8'hA5, 8'h0F, 8'h35};
        vecs[3] = '{8'hFF, 8'h0F, 8'h3C, 1'b1, 8'hFF, 8'h0F, 8'h3F};
        vecs[4] = '{8'h00, 8'hFF, 8'hAA, 1'b1, 8'h00, 8'hFF, 8'h00};
        vecs[5] = '{8'h5A, 8'h00, 8'hC3, 1'b1, 8'h5A, 8'h00, 8'hC3};
        vecs[6] = '{8'h3C, 8'hF0, 8'h0F, 1'b1, 8'h3C, 8'hF0, 8'h3F};
        vecs[7] = '{8'h81, 8'h81, 8'h7E, 1'b0, 8'h3C, 8'h81, 8'h7E};

        reset = 1'b1;
        io_if.clock_enable  = 1'b1; io_if.d_out  = 8'h00; io_if.output_enable  = 8'hFF; io_if.pad_in  = 8'hFF;
        out_if.clock_enable = 1'b1; out_if.d_out = 1'b0;  out_if.output_enable = 1'b0;  out_if.pad_in = 1'b1;
        in_if.clock_enable  = 1'b1; in_if.d_out  = 1'b0;  in_if.output_enable  = 1'b0;  in_if.pad_in  = 1'b0;
        rgn_if.clock_enable = 1'b1; rgn_if.d_out = 1'b0;  rgn_if.output_enable = 1'b0;  rgn_if.pad_in = 1'b0;
        und_if.clock_enable = 1'b1; und_if.d_out = 1'b0;  und_if.output_enable = 1'b0;  und_if.pad_in = 1'b0;
        dir_if.clock_enable = 1'b1; dir_if.d_out = 4'h0;  dir_if.output_enable = 4'h0;  dir_if.pad_in = 4'h6;

        #12;
        chk("rst_io_pad_out", io_if.pad_out, 8'h00);
        chk("rst_io_pad_oe", io_if.pad_oe, 8'hFF);
        chk("rst_io_d_in", io_if.d_in, 8'h00);
        chk("rst_out_pad_out", 8'(out_if.pad_out), 8'h00);
        chk("rst_out_pad_oe", 8'(out_if.pad_oe), 8'h01);
        chk("rst_out_d_in", 8'(out_if.d_in), 8'h00);
        chk("rst_in_d_in", 8'(in_if.d_in), 8'h00);
        chk("rst_rgn_pad_oe", 8'(rgn_if.pad_oe), 8'h00);

        // reset wins over clock_enable
        io_if.d_out = 8'hA5;
        tick();
        chk("rst_prio_io_pad_out", io_if.pad_out, 8'h00);
        #3 reset = 1'b0;
        io_if.d_out = 8'h00;
        tick();

        for (int i = 0; i < 8; i++) begin
            io_if.d_out         = vecs[i].d_out;
            io_if.output_enable = vecs[i].oe;
            io_if.pad_in        = vecs[i].pin;
            io_if.clock_enable  = vecs[i].ce;
            tick();
            chk($sformatf("vec%0d_pad_out", i), io_if.pad_out, vecs[i].exp_po);
            chk($sformatf("vec%0d_pad_oe", i), io_if.pad_oe, vecs[i].exp_oe);
            chk($sformatf("vec%0d_d_in", i), io_if.d_in, vecs[i].exp_din);
        end

        // registered output, direct input: readback the same cycle
        out_if.pad_in = 1'b0;
        out_if.d_out  = 1'b1;
        tick();
        chk("out_pad_out", 8'(out_if.pad_out), 8'h01);
        chk("out_d_in", 8'(out_if.d_in), 8'h01);

        // registered input: pad change mid-cycle only seen after next clk
        #2 in_if.pad_in = 1'b1;
        #1;
        chk("in_d_in_hold", 8'(in_if.d_in), 8'h00);
        chk("in_pad_oe", 8'(in_if.pad_oe), 8'h00);
        tick();
        chk("in_d_in_clk", 8'(in_if.d_in), 8'h01);
        chk("in_pad_oe_clk", 8'(in_if.pad_oe), 8'h00);

        // registered enable
        rgn_if.output_enable = 1'b1;
        #1;
        chk("rgn_pad_oe_pre", 8'(rgn_if.pad_oe), 8'h00);
        tick();
        chk("rgn_pad_oe_post", 8'(rgn_if.pad_oe), 8'h01);

        // undefined output code and latch input mode
        und_if.d_out = 1'b1;
        und_if.output_enable = 1'b1;
        und_if.pad_in = 1'b1;
        #1;
        chk("und_d_in_hi", 8'(und_if.d_in), 8'h01);
        chk("und_pad_oe_a", 8'(und_if.pad_oe), 8'h00);
        und_if.pad_in = 1'b0;
        #1;
        chk("und_d_in_lo", 8'(und_if.d_in), 8'h00);
        tick();
        chk("und_pad_oe_b", 8'(und_if.pad_oe), 8'h00);
        chk("und_pad_out", 8'(und_if.pad_out), 8'h00);

        // direct output looped to direct input
        dir_if.d_out = 4'h9;
        #1;
        chk("dir_pad_out", 8'(dir_if.pad_out), 8'h09);
        chk("dir_pad_oe", 8'(dir_if.pad_oe), 8'h0F);
        chk("dir_d_in", 8'(dir_if.d_in), 8'h09);

        // asynchronous reset mid-cycle
        tick();
        #2 reset = 1'b1;
        #1;
        chk("arst_in_d_in", 8'(in_if.d_in), 8'h00);
        chk("arst_rgn_pad_oe", 8'(rgn_if.pad_oe), 8'h00);
        chk("arst_out_pad_out", 8'(out_if.pad_out), 8'h00);
        chk("arst_io_pad_out", io_if.pad_out, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
